// File: rtl/fixed_float_convert_pipe.sv
// Streaming fixed-point <-> IEEE-754 single converter.
// Three stages: unpack, normalise/align, round/pack.
package fixed_float_convert_pipe_pkg;

  typedef struct packed {
    logic        valid;
    logic        op;
    logic        sign;
    logic        zero;
    logic        nan;
    logic        inf;
    logic        big;
    logic        tiny;
    logic        fnz;
    logic [10:0] sh;
    logic [4:0]  fp;
    logic [31:0] val;
  } s1_t;

  typedef struct packed {
    logic        valid;
    logic        op;
    logic        sign;
    logic        zero;
    logic        nan;
    logic        inf;
    logic        big;
    logic        tiny;
    logic        fnz;
    logic [7:0]  exp;
    logic [30:0] norm;
    logic [32:0] mag;
    logic        frac;
  } s2_t;

endpackage

module fixed_float_convert_pipe
  import fixed_float_convert_pipe_pkg::*;
#(
  parameter int FIX_W  = 32,
  parameter int FPOS_W = 5,
  parameter bit SIGNED = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              opcode,
  input  logic [FPOS_W-1:0] fixpointpos,
  input  logic [31:0]       targetnumber,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [31:0]       result,
  output logic              flag_inexact,
  output logic              flag_overflow,
  output logic              flag_invalid
);

  localparam logic signed [10:0] BIG_SH =
    11'(FIX_W - 23);
  localparam logic signed [10:0] TINY_SH =
    -11'sd32;
  localparam logic [32:0] MAG_POS = SIGNED ?
    (33'd1 << (FIX_W - 1)) - 33'd1 :
    (33'd1 << FIX_W) - 33'd1;
  localparam logic [32:0] MAG_NEG =
    33'd1 << (FIX_W - 1);
  localparam logic [FIX_W-1:0] SAT_POS =
    MAG_POS[FIX_W-1:0];
  localparam logic [FIX_W-1:0] SAT_NEG =
    SIGNED ? MAG_NEG[FIX_W-1:0] : '0;

  function automatic logic [31:0] ext(
    input logic [FIX_W-1:0] v
  );
    if (SIGNED) return 32'($signed(v));
    else return 32'(v);
  endfunction

  logic adv;
  s1_t  s1_d, s1_q;
  s2_t  s2_d, s2_q;

  assign adv      = !out_valid || out_ready;
  assign in_ready = adv;

  logic [FIX_W-1:0]   fx, fmag;
  logic               fneg;
  logic [4:0]         fpc;
  logic [7:0]         fe;
  logic signed [10:0] sh;

  always_comb begin
    fpc = (int'(fixpointpos) >= FIX_W) ?
      5'(FIX_W - 1) : 5'(fixpointpos);
    fx   = targetnumber[FIX_W-1:0];
    fneg = SIGNED && fx[FIX_W-1];
    fmag = fneg ? -fx : fx;
    fe   = targetnumber[30:23];
    sh   = $signed(11'(fe)) +
           $signed(11'(fpc)) - 11'sd150;
    s1_d       = '0;
    s1_d.valid = in_valid;
    s1_d.op    = opcode;
    s1_d.fp    = fpc;
    if (!opcode) begin
      s1_d.sign = fneg;
      s1_d.zero = (fx == '0);
      s1_d.val  = 32'(fmag);
    end else begin
      s1_d.sign = targetnumber[31];
      s1_d.zero = (fe == 8'd0);
      s1_d.fnz  = (targetnumber[22:0] != '0);
      s1_d.nan  = (fe == 8'hFF) && s1_d.fnz;
      s1_d.inf  = (fe == 8'hFF) && !s1_d.fnz;
      s1_d.big  = (sh > BIG_SH);
      s1_d.tiny = (sh < TINY_SH);
      s1_d.sh   = sh;
      s1_d.val  = {8'd0, 1'b1, targetnumber[22:0]};
    end
  end

  logic [4:0]  msb;
  logic [5:0]  lsh;
  logic [64:0] q;

  // q holds the aligned magnitude with 32 fraction bits
  always_comb begin
    msb = '0;
    for (int i = 0; i < 32; i++)
      if (s1_q.val[i]) msb = 5'(i);
    lsh = 6'($signed(s1_q.sh) + 11'sd32);
    q   = 65'(s1_q.val[23:0]) << lsh;
    s2_d       = '0;
    s2_d.valid = s1_q.valid;
    s2_d.op    = s1_q.op;
    s2_d.sign  = s1_q.sign;
    s2_d.zero  = s1_q.zero;
    s2_d.nan   = s1_q.nan;
    s2_d.inf   = s1_q.inf;
    s2_d.big   = s1_q.big;
    s2_d.tiny  = s1_q.tiny;
    s2_d.fnz   = s1_q.fnz;
    s2_d.exp   = 8'd127 + 8'(msb) - 8'(s1_q.fp);
    s2_d.norm  = 31'(s1_q.val << (5'd31 - msb));
    s2_d.mag   = q[64:32];
    s2_d.frac  = |q[31:0];
  end

  logic             rup, cry, f_inx;
  logic [22:0]      frc;
  logic [7:0]       fexp;
  logic [31:0]      f_res, x_res;
  logic             x_inx, x_ovf, x_inv;
  logic [FIX_W-1:0] fixr;

  always_comb begin
    rup = s2_q.norm[7] &&
          ((|s2_q.norm[6:0]) || s2_q.norm[8]);
    cry   = rup && (&s2_q.norm[30:8]);
    frc   = s2_q.norm[30:8] + 23'(rup);
    fexp  = s2_q.exp + 8'(cry);
    f_res = s2_q.zero ? 32'd0 :
            {s2_q.sign, fexp, frc};
    f_inx = !s2_q.zero &&
            (s2_q.norm[7] || (|s2_q.norm[6:0]));

    fixr  = s2_q.mag[FIX_W-1:0];
    x_res = '0;
    x_inx = 1'b0;
    x_ovf = 1'b0;
    x_inv = 1'b0;
    if (s2_q.nan) begin
      x_inv = 1'b1;
    end else if (s2_q.zero) begin
      x_inx = s2_q.fnz;
    end else if (!SIGNED && s2_q.sign) begin
      x_ovf = 1'b1;
    end else if (s2_q.inf || s2_q.big) begin
      x_ovf = 1'b1;
      x_res = ext(s2_q.sign ? SAT_NEG : SAT_POS);
    end else if (s2_q.tiny) begin
      x_inx = 1'b1;
    end else if (s2_q.mag >
                 (s2_q.sign ? MAG_NEG : MAG_POS)) begin
      x_ovf = 1'b1;
      x_res = ext(s2_q.sign ? SAT_NEG : SAT_POS);
    end else begin
      x_res = ext(s2_q.sign ? -fixr : fixr);
      x_inx = s2_q.frac;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1_q          <= '0;
      s2_q          <= '0;
      out_valid     <= 1'b0;
      result        <= '0;
      flag_inexact  <= 1'b0;
      flag_overflow <= 1'b0;
      flag_invalid  <= 1'b0;
    end else if (adv) begin
      s1_q          <= s1_d;
      s2_q          <= s2_d;
      out_valid     <= s2_q.valid;
      result        <= s2_q.op ? x_res : f_res;
      flag_inexact  <= s2_q.op ? x_inx : f_inx;
      flag_overflow <= s2_q.op && x_ovf;
      flag_invalid  <= s2_q.op && x_inv;
    end
  end

endmodule

// File: tb/tb_fixed_float_convert_pipe.sv
// Directed bench for fixed_float_convert_pipe:
// signed and unsigned instances, stalls, reset.
module tb_fixed_float_convert_pipe;

  typedef struct packed {
    logic        op;
    logic [4:0]  fp;
    logic [31:0] tn;
    logic [31:0] res;
    logic [2:0]  fl;
  } vec_t;

  localparam int NV = 20;

  // flags are {inexact, overflow, invalid}
  vec_t tab [NV] = '{
    '{1'b0, 5'd2,  32'h00000065, 32'h41CA0000, 3'b000},
    '{1'b1, 5'd2,  32'h41CA0000, 32'h00000065, 3'b000},
    '{1'b0, 5'd2,  32'hFFFFFF9B, 32'hC1CA0000, 3'b000},
    '{1'b0, 5'd0,  32'h01000001, 32'h4B800000, 3'b100},
    '{1'b0, 5'd0,  32'h01000003, 32'h4B800002, 3'b100},
    '{1'b0, 5'd0,  32'h80000000, 32'hCF000000, 3'b000},
    '{1'b1, 5'd0,  32'h4F800000, 32'h7FFFFFFF, 3'b010},
    '{1'b1, 5'd0,  32'hFF800000, 32'h80000000, 3'b010},
    '{1'b1, 5'd0,  32'h7FC00000, 32'h00000000, 3'b001},
    '{1'b1, 5'd0,  32'h3FC00000, 32'h00000001, 3'b100},
    '{1'b0, 5'd0,  32'h00000000, 32'h00000000, 3'b000},
    '{1'b1, 5'd0,  32'h80000000, 32'h00000000, 3'b000},
    '{1'b1, 5'd0,  32'h00000001, 32'h00000000, 3'b100},
    '{1'b1, 5'd0,  32'hBFC00000, 32'hFFFFFFFF, 3'b100},
    '{1'b0, 5'd31, 32'h00000001, 32'h30000000, 3'b000},
    '{1'b1, 5'd0,  32'hCF000000, 32'h80000000, 3'b000},
    '{1'b0, 5'd0,  32'h7FFFFFFF, 32'h4F000000, 3'b100},
    '{1'b1, 5'd4,  32'h3F800000, 32'h00000010, 3'b000},
    '{1'b1, 5'd0,  32'h4F000000, 32'h7FFFFFFF, 3'b010},
    '{1'b0, 5'd0,  32'hFFFFFFFF, 32'hBF800000, 3'b000}
  };

  vec_t utab [3] = '{
    '{1'b1, 5'd0, 32'hBF800000, 32'h00000000, 3'b010},
    '{1'b1, 5'd0, 32'h4F000000, 32'h80000000, 3'b000},
    '{1'b0, 5'd0, 32'h80000000, 32'h4F000000, 3'b000}
  };

  logic        clk = 1'b0;
  logic        rst;
  logic        opcode;
  logic [4:0]  fixpointpos;
  logic [31:0] targetnumber;
  logic        in_valid_s, in_ready_s;
  logic        out_valid_s, out_ready_s;
  logic [31:0] result_s;
  logic        inx_s, ovf_s, inv_s;
  logic        in_valid_u, in_ready_u;
  logic        out_valid_u, out_ready_u;
  logic [31:0] result_u;
  logic        inx_u, ovf_u, inv_u;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  fixed_float_convert_pipe #(
    .FIX_W(32), .FPOS_W(5), .SIGNED(1)
  ) dut_s (
    .clk(clk), .rst(rst),
    .in_valid(in_valid_s), .in_ready(in_ready_s),
    .opcode(opcode), .fixpointpos(fixpointpos),
    .targetnumber(targetnumber),
    .out_valid(out_valid_s), .out_ready(out_ready_s),
    .result(result_s), .flag_inexact(inx_s),
    .flag_overflow(ovf_s), .flag_invalid(inv_s)
  );

  fixed_float_convert_pipe #(
    .FIX_W(32), .FPOS_W(5), .SIGNED(0)
  ) dut_u (
    .clk(clk), .rst(rst),
    .in_valid(in_valid_u), .in_ready(in_ready_u),
    .opcode(opcode), .fixpointpos(fixpointpos),
    .targetnumber(targetnumber),
    .out_valid(out_valid_u), .out_ready(out_ready_u),
    .result(result_u), .flag_inexact(inx_u),
    .flag_overflow(ovf_u), .flag_invalid(inv_u)
  );

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h",
             tag, obs, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    opcode       = v.op;
    fixpointpos  = v.fp;
    targetnumber = v.tn;
  endtask

  // one isolated transaction; entered and left at posedge+1
  task automatic send(input bit uns,
                      input vec_t v,
                      input string tag);
    drive(v);
    if (uns) in_valid_u = 1'b1;
    else in_valid_s = 1'b1;
    #1;
    chk({tag, ".rdy"}, 32'(uns ? in_ready_u : in_ready_s), 1);
    @(posedge clk); #1;
    in_valid_s = 1'b0;
    in_valid_u = 1'b0;
    chk({tag, ".lat1"},
        32'(uns ? out_valid_u : out_valid_s), 0);
    @(posedge clk); #1;
    chk({tag, ".lat2"},
        32'(uns ? out_valid_u : out_valid_s), 0);
    @(posedge clk); #1;
    chk({tag, ".lat3"},
        32'(uns ? out_valid_u : out_valid_s), 1);
    chk({tag, ".res"},
        uns ? result_u : result_s, v.res);
    chk({tag, ".flg"},
        uns ? 32'({inx_u, ovf_u, inv_u}) :
              32'({inx_s, ovf_s, inv_s}),
        32'(v.fl));
    @(posedge clk); #1;
  endtask

  initial begin
    int acc, got, sent, cur, vcnt;
    bit fin, fout;
    int expq [$];

    rst = 1'b0;
    in_valid_s = 1'b0; in_valid_u = 1'b0;
    out_ready_s = 1'b1; out_ready_u = 1'b1;
    opcode = 1'b0; fixpointpos = '0;
    targetnumber = '0;
    #1;
    chk("rst.ov", 32'(out_valid_s), 0);
    chk("rst.res", result_s, 0);
    chk("rst.flg", 32'({inx_s, ovf_s, inv_s}), 0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    #1;
    chk("rel.rdy", 32'(in_ready_s), 1);
    @(posedge clk); #1;

    for (int i = 0; i < NV; i++)
      send(1'b0, tab[i], $sformatf("vec%0d", i));
    for (int i = 0; i < 3; i++)
      send(1'b1, utab[i], $sformatf("uvec%0d", i));

    // five back-to-back requests into a blocked output
    out_ready_s = 1'b0;
    acc = 0;
    for (int c = 0; c < 8; c++) begin
      in_valid_s = (acc < 5);
      if (acc < 5) drive(tab[acc]);
      #1;
      fin = in_valid_s && in_ready_s;
      @(posedge clk); #1;
      if (fin) acc++;
    end
    chk("bp.accepted", acc, 3);
    chk("bp.rdy", 32'(in_ready_s), 0);
    for (int c = 0; c < 3; c++) begin
      chk("bp.ov", 32'(out_valid_s), 1);
      chk("bp.hold", result_s, tab[0].res);
      @(posedge clk); #1;
    end
    out_ready_s = 1'b1;
    got = 0;
    for (int c = 0; c < 30 && got < 5; c++) begin
      in_valid_s = (acc < 5);
      if (acc < 5) drive(tab[acc]);
      #1;
      fin  = in_valid_s && in_ready_s;
      fout = out_valid_s && out_ready_s;
      if (fout) begin
        chk($sformatf("bp.res%0d", got),
            result_s, tab[got].res);
        chk($sformatf("bp.flg%0d", got),
            32'({inx_s, ovf_s, inv_s}),
            32'(tab[got].fl));
        got++;
      end
      @(posedge clk); #1;
      if (fin) acc++;
    end
    chk("bp.count", got, 5);
    in_valid_s = 1'b0;
    vcnt = 0;
    repeat (5) begin
      if (out_valid_s) vcnt++;
      @(posedge clk); #1;
    end
    chk("bp.nodup", vcnt, 0);

    // mixed stream with random output stalls
    sent = 0; got = 0;
    cur = $urandom_range(0, NV - 1);
    for (int c = 0; c < 4000 && got < 300; c++) begin
      in_valid_s  = (sent < 300);
      drive(tab[cur]);
      out_ready_s = 1'($urandom_range(0, 1));
      #1;
      fin  = in_valid_s && in_ready_s;
      fout = out_valid_s && out_ready_s;
      if (fout) begin
        if (expq.size() == 0) begin
          chk("rnd.extra", 1, 0);
        end else begin
          chk("rnd.res", result_s,
              tab[expq[0]].res);
          chk("rnd.flg",
              32'({inx_s, ovf_s, inv_s}),
              32'(tab[expq[0]].fl));
          void'(expq.pop_front());
        end
        got++;
      end
      @(posedge clk); #1;
      if (fin) begin
        expq.push_back(cur);
        sent++;
        cur = $urandom_range(0, NV - 1);
      end
    end
    chk("rnd.count", got, 300);
    in_valid_s  = 1'b0;
    out_ready_s = 1'b1;
    repeat (4) @(posedge clk);
    #1;

    // reset with three in flight and a held output
    out_ready_s = 1'b0;
    in_valid_s  = 1'b1;
    drive(tab[0]);
    repeat (4) @(posedge clk);
    #1;
    chk("rf.ov", 32'(out_valid_s), 1);
    #2 rst = 1'b0;
    #1;
    chk("rf.ov0", 32'(out_valid_s), 0);
    chk("rf.res0", result_s, 0);
    chk("rf.flg0",
        32'({inx_s, ovf_s, inv_s}), 0);
    in_valid_s = 1'b0;
    repeat (2) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("rf.rdy", 32'(in_ready_s), 1);
    out_ready_s = 1'b1;
    vcnt = 0;
    repeat (6) begin
      @(posedge clk); #1;
      if (out_valid_s) vcnt++;
    end
    chk("rf.stale", vcnt, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
